// File: rtl/voting_pkg.sv
// voting_pkg: shared constants for the five-voter majority voter
//   N_VOTERS          number of 1-bit votes
//   CNT_W             width of the vote count (0..5)
//   DEFAULT_THRESHOLD strict majority of five
package voting_pkg;
  localparam int N_VOTERS = 5;
  localparam int CNT_W = 3;
  localparam int DEFAULT_THRESHOLD = 3;
endpackage

// File: rtl/voting_m_popcount5.sv
// popcount5: combinational count of ones in a 5-bit vector
//   in_i  [4:0] votes
//   cnt_o [2:0] number of ones, 0..5
module popcount5
  import voting_pkg::*;
(
  input  logic [N_VOTERS-1:0] in_i,
  output logic [CNT_W-1:0]    cnt_o
);
  logic s1, c1, c2;
  // first full adder folds in[4:2]; second folds in[1:0] with that sum;
  // the two weight-2 carries meet in a half adder for bits 1 and 2
  always_comb begin
    s1 = in_i[4] ^ in_i[3] ^ in_i[2];
    c1 = (in_i[4] & in_i[3]) | (in_i[2] & (in_i[4] ^ in_i[3]));
    c2 = (in_i[1] & in_i[0]) | (s1 & (in_i[1] ^ in_i[0]));
    cnt_o = {c1 & c2, c1 ^ c2, in_i[1] ^ in_i[0] ^ s1};
  end
endmodule

// File: rtl/voting_m.sv
// voting_m: registered five-voter threshold voter
//   clk        rising-edge clock
//   rst_n      synchronous active-low clear of all outputs
//   A..E       votes, 1 = yes
//   F          registered (count >= THRESHOLD)
//   vote_cnt   registered number of yes votes
//   unanimous  registered flag, all votes equal
module voting_m
  import voting_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             E,
  output logic             F,
  output logic [CNT_W-1:0] vote_cnt,
  output logic             unanimous
);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ALL = CNT_W'(N_VOTERS);
  if (THRESHOLD < 1 || THRESHOLD > N_VOTERS) begin : g_bad_threshold
    $error("voting_m: THRESHOLD %0d outside 1..%0d", THRESHOLD, N_VOTERS);
  end
  logic [CNT_W-1:0] cnt_c, cnt_d, cnt_q;
  logic             f_d, f_q, unan_d, unan_q;
  popcount5 u_pop (.in_i({A, B, C, D, E}), .cnt_o(cnt_c));
  always_comb begin
    cnt_d  = rst_n ? cnt_c : '0;
    f_d    = rst_n && (cnt_c >= THR);
    unan_d = rst_n && (cnt_c == '0 || cnt_c == ALL);
  end
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    f_q    <= f_d;
    unan_q <= unan_d;
  end
  assign F         = f_q;
  assign vote_cnt  = cnt_q;
  assign unanimous = unan_q;
endmodule

// File: tb/tb_voting_m.sv
// tb_voting_m: directed self-checking bench for voting_m at THRESHOLD 3, 5 and 1
module tb_voting_m;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic       f3, f5, f1, u3, u5, u1;
  logic [2:0] n3, n5, n1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  voting_m #(.THRESHOLD(3)) dut3 (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .E(e),
                                  .F(f3), .vote_cnt(n3), .unanimous(u3));
  voting_m #(.THRESHOLD(5)) dut5 (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .E(e),
                                  .F(f5), .vote_cnt(n5), .unanimous(u5));
  voting_m #(.THRESHOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .E(e),
                                  .F(f1), .vote_cnt(n1), .unanimous(u1));
  task automatic step(input logic [4:0] v, input logic r);
    @(negedge clk);
    {a, b, c, d, e} = v;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    step(5'b11111, 1'b0);
    checks++;
    if ({f3, n3, u3} !== 5'b0 || {f5, n5, u5} !== 5'b0 || {f1, n1, u1} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hold: got F=%b cnt=%0d unan=%b (t5 %b%0d%b t1 %b%0d%b) want 0 0 0",
               f3, n3, u3, f5, n5, u5, f1, n1, u1);
    end
    step(5'b11111, 1'b1);
    checks++;
    if (f3 !== 1'b1 || n3 !== 3'd5 || u3 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got F=%b cnt=%0d unan=%b want 1 5 1", f3, n3, u3);
    end
  endtask
  task automatic test_directed();
    logic [4:0] vec [8] = '{5'b00000, 5'b10000, 5'b11000, 5'b10100,
                            5'b11100, 5'b10101, 5'b10111, 5'b11111};
    logic [2:0] ecnt [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5};
    logic       ef   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       eu   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(vec[i], 1'b1);
      checks++;
      if (f3 !== ef[i] || n3 !== ecnt[i] || u3 !== eu[i]) begin
        failures++;
        $display("FAIL directed %b: got F=%b cnt=%0d unan=%b want %b %0d %b",
                 vec[i], f3, n3, u3, ef[i], ecnt[i], eu[i]);
      end
    end
  endtask
  task automatic test_sweep(input int rst_at);
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic       r;
      int         k;
      logic [2:0] en;
      logic       e3, e5, e1, eu;
      v  = 5'(i);
      r  = (i != rst_at);
      k  = $countones(v);
      en = r ? 3'(k) : 3'd0;
      e3 = r && k >= 3;
      e5 = r && k >= 5;
      e1 = r && k >= 1;
      eu = r && (k == 0 || k == 5);
      step(v, r);
      checks++;
      if (f3 !== e3 || n3 !== en || u3 !== eu || f5 !== e5 || f1 !== e1 ||
          n5 !== en || n1 !== en || u5 !== eu || u1 !== eu) begin
        failures++;
        $display("FAIL sweep %b rst_n=%b: got F3=%b F5=%b F1=%b cnt=%0d unan=%b want %b %b %b %0d %b",
                 v, r, f3, f5, f1, n3, u3, e3, e5, e1, en, eu);
      end
    end
  endtask
  task automatic test_threshold();
    step(5'b11110, 1'b1);
    checks++;
    if (f5 !== 1'b0) begin
      failures++;
      $display("FAIL thr5_11110: got F=%b want 0", f5);
    end
    step(5'b11111, 1'b1);
    checks++;
    if (f5 !== 1'b1) begin
      failures++;
      $display("FAIL thr5_11111: got F=%b want 1", f5);
    end
    step(5'b00000, 1'b1);
    checks++;
    if (f1 !== 1'b0) begin
      failures++;
      $display("FAIL thr1_00000: got F=%b want 0", f1);
    end
    step(5'b00001, 1'b1);
    checks++;
    if (f1 !== 1'b1) begin
      failures++;
      $display("FAIL thr1_00001: got F=%b want 1", f1);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_sweep(-1);
    test_sweep(16);
    test_threshold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
